// File: rtl/dac_rx_if.sv
// 3-wire TLV5618-style serial link (cs_n/sclk/din) shared by the serialiser and this receiver.
interface dac_rx_if;
  logic cs_n;
  logic sclk;
  logic din;

  modport master (output cs_n, output sclk, output din);
  modport slave  (input  cs_n, input  sclk, input  din);
endinterface

// File: rtl/dac_rx.sv
// Oversampling receiver for the TLV5618 serial link: deserialises 16-bit frames, checks framing
// and decodes the command into DAC A/B/buffer registers.
module dac_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  dac_rx_if.slave     link,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  err_code,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic        spd,
  output logic        pwr,
  output logic [1:0]  state_dbg
);

  // rx_valid and rx_err are single-cycle pulses with no back-pressure: the consumer must take
  // rx_data/dac_a/dac_b/spd/pwr (on rx_valid) or err_code (on rx_err) in the pulse cycle.

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] FB_CNT = CW'(FRAME_BITS);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_FULL = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [15:0]   shreg, sh_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          ovr_pend, ovr_nxt;
  logic          valid_nxt, err_nxt;
  logic [1:0]    code_nxt;
  logic [11:0]   buffer;

  // Equal-depth sync + history chains keep cs_n/sclk/din edge ordering intact.
  logic cs_s1, cs_s2, cs_h;
  logic sk_s1, sk_s2, sk_h;
  logic di_s1, di_s2, di_h;
  logic cs_fall, cs_rise, sclk_fall;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1 <= 1'b1; cs_s2 <= 1'b1; cs_h <= 1'b1;
      sk_s1 <= 1'b0; sk_s2 <= 1'b0; sk_h <= 1'b0;
      di_s1 <= 1'b1; di_s2 <= 1'b1; di_h <= 1'b1;
    end else begin
      cs_s1 <= link.cs_n; cs_s2 <= cs_s1; cs_h <= cs_s2;
      sk_s1 <= link.sclk; sk_s2 <= sk_s1; sk_h <= sk_s2;
      di_s1 <= link.din;  di_s2 <= di_s1; di_h <= di_s2;
    end
  end

  assign cs_fall   = cs_h & ~cs_s2;
  assign cs_rise   = ~cs_h & cs_s2;
  assign sclk_fall = sk_h & ~sk_s2;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    sh_nxt    = shreg;
    to_nxt    = to_cnt;
    ovr_nxt   = ovr_pend;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    case (state)
      S_IDLE: begin
        if (cs_fall) begin
          state_nxt = S_RECV;
          cnt_nxt   = '0;
          to_nxt    = '0;
          ovr_nxt   = 1'b0;
        end
      end
      S_RECV: begin
        if (sclk_fall) begin
          sh_nxt  = {shreg[14:0], di_s2};
          cnt_nxt = bit_cnt + CW'(1);
          to_nxt  = '0;
        end else if (TIMEOUT_CYC != 0) begin
          to_nxt = to_cnt + TW'(1);
        end
        // Frame end is judged on the count after any same-cycle shift; cs_n rise beats timeout.
        if (cs_rise) begin
          state_nxt = S_IDLE;
          if (cnt_nxt == FB_CNT) begin
            valid_nxt = 1'b1;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 2'b01;
          end
        end else if (cnt_nxt == FB_CNT) begin
          state_nxt = S_FULL;
        end else if ((TIMEOUT_CYC != 0) && (to_nxt == TO_LIM)) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
          code_nxt  = 2'b11;
        end
      end
      S_FULL: begin
        if (sclk_fall) begin
          code_nxt = 2'b10;
          if (cs_rise) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
            ovr_nxt   = 1'b0;
          end else begin
            state_nxt = S_ERR;
            ovr_nxt   = 1'b1;
          end
        end else if (cs_rise) begin
          state_nxt = S_IDLE;
          valid_nxt = 1'b1;
        end
      end
      S_ERR: begin
        // Overrun is reported at frame end; a timeout was already reported when it fired.
        if (cs_rise) begin
          state_nxt = S_IDLE;
          err_nxt   = ovr_pend;
          ovr_nxt   = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      to_cnt   <= '0;
      ovr_pend <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= 2'b00;
      rx_data  <= '0;
      dac_a    <= '0;
      dac_b    <= '0;
      buffer   <= '0;
      spd      <= 1'b0;
      pwr      <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      shreg    <= sh_nxt;
      to_cnt   <= to_nxt;
      ovr_pend <= ovr_nxt;
      rx_valid <= valid_nxt;
      rx_err   <= err_nxt;
      err_code <= code_nxt;
      if (valid_nxt) begin
        rx_data <= sh_nxt;
        spd     <= sh_nxt[14];
        pwr     <= sh_nxt[13];
        // Command select: R1 = bit 15, R0 = bit 12; 2'b11 is reserved and leaves the DAC state alone.
        case ({sh_nxt[15], sh_nxt[12]})
          2'b00: begin
            dac_b  <= sh_nxt[11:0];
            buffer <= sh_nxt[11:0];
          end
          2'b01: buffer <= sh_nxt[11:0];
          2'b10: begin
            dac_a <= sh_nxt[11:0];
            dac_b <= buffer;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_rx.sv
// Directed bench for dac_rx: drives serial frames, predicts each rx_valid/rx_err event with a
// small register model and compares events as the DUT emits them.
module tb_dac_rx;

  localparam int W = 45;

  logic        clk_50mhz;
  logic        rst_n;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  err_code;
  logic [11:0] dac_a;
  logic [11:0] dac_b;
  logic        spd;
  logic        pwr;
  logic [1:0]  state_dbg;

  dac_rx_if link ();

  dac_rx #(.FRAME_BITS(16), .TIMEOUT_CYC(1024)) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .link      (link),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .err_code  (err_code),
    .dac_a     (dac_a),
    .dac_b     (dac_b),
    .spd       (spd),
    .pwr       (pwr),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_evt_cyc = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [15:0] m_data;
  logic [11:0] m_a, m_b, m_buf;
  logic        m_spd, m_pwr;
  logic [1:0]  m_code;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  function automatic logic [W-1:0] pack(input logic kind, input logic [1:0] code,
                                        input logic [15:0] data, input logic [11:0] a,
                                        input logic [11:0] b, input logic s, input logic p);
    return {kind, code, data, a, b, s, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_a = '0; m_b = '0; m_buf = '0; m_spd = 1'b0; m_pwr = 1'b0; m_code = 2'b00;
  endtask

  task automatic push_good(input logic [15:0] v);
    case ({v[15], v[12]})
      2'b00: begin m_b = v[11:0]; m_buf = v[11:0]; end
      2'b01: m_buf = v[11:0];
      2'b10: begin m_a = v[11:0]; m_b = m_buf; end
      default: ;
    endcase
    m_data = v; m_spd = v[14]; m_pwr = v[13];
    exp_q.push_back(pack(1'b0, m_code, m_data, m_a, m_b, m_spd, m_pwr));
  endtask

  task automatic push_err(input logic [1:0] code);
    m_code = code;
    exp_q.push_back(pack(1'b1, m_code, m_data, m_a, m_b, m_spd, m_pwr));
  endtask

  // scoreboard: every event pops and compares one prediction
  always @(negedge clk_50mhz) begin
    logic [W-1:0] obs, exp;
    if (rst_n && (rx_valid || rx_err)) begin
      obs = pack(rx_err, err_code, rx_data, dac_a, dac_b, spd, pwr);
      last_evt_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed=%0h expected=none", obs);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL scoreboard: observed=%0h expected=%0h", obs, exp);
        end
      end
      checks++;
      assert (!(rx_valid && rx_err)) else begin
        errors++;
        $error("FAIL both_pulses: observed=11 expected=single");
      end
    end
  end

  // 12.5 MHz sclk: each phase is two clk_50mhz cycles; inputs change on clk_50mhz falling edges.
  task automatic send_frame(input logic [31:0] val, input int nbits, input bit simul,
                            input bit expect_pulse, input string tag);
    @(negedge clk_50mhz);
    link.cs_n = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    for (int i = nbits - 1; i >= 0; i--) begin
      link.din  = val[i];
      link.sclk = 1'b1;
      repeat (2) @(negedge clk_50mhz);
      link.sclk = 1'b0;
      if (simul && i == 0) link.cs_n = 1'b1;
      else repeat (2) @(negedge clk_50mhz);
    end
    link.cs_n = 1'b1;
    link.din  = 1'b1;
    repeat (2) @(posedge clk_50mhz);
    #1 check({tag, "_early"}, {31'd0, rx_valid | rx_err}, 32'd0);
    @(posedge clk_50mhz);
    #1 check({tag, "_latency"}, {31'd0, rx_valid | rx_err}, {31'd0, expect_pulse});
    repeat (4) @(negedge clk_50mhz);
  endtask

  initial begin
    logic [15:0] rv;
    int t0;
    rst_n = 1'b0;
    link.cs_n = 1'b1;
    link.sclk = 1'b0;
    link.din  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_50mhz);
    check("rst_rx_data", {16'd0, rx_data}, 32'd0);
    check("rst_pulses", {29'd0, rx_valid, rx_err, 1'b0}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_dac", {8'd0, dac_a, dac_b}, 32'd0);
    check("rst_spd_pwr", {30'd0, spd, pwr}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50mhz);

    // write DAC B and buffer
    push_good(16'h0ABC);
    send_frame(32'h0ABC, 16, 1'b0, 1'b1, "f0abc");
    check("f0abc_data", {16'd0, rx_data}, 32'h0ABC);
    check("f0abc_dacb", {20'd0, dac_b}, 32'hABC);
    check("f0abc_daca", {20'd0, dac_a}, 32'h0);

    // buffer load then DAC A with buffer transfer to B
    push_good(16'h1123);
    send_frame(32'h1123, 16, 1'b0, 1'b1, "f1123");
    push_good(16'h8456);
    send_frame(32'h8456, 16, 1'b0, 1'b1, "f8456");
    check("f8456_daca", {20'd0, dac_a}, 32'h456);
    check("f8456_dacb", {20'd0, dac_b}, 32'h123);

    // short frame
    push_err(2'b01);
    send_frame(32'h03FF, 10, 1'b0, 1'b1, "short");
    check("short_code", {30'd0, err_code}, 32'd1);
    check("short_data", {16'd0, rx_data}, 32'h8456);

    // overrun then a good frame carrying spd/pwr
    push_err(2'b10);
    send_frame(32'h1FFFF, 17, 1'b0, 1'b1, "ovr");
    check("ovr_code", {30'd0, err_code}, 32'd2);
    push_good(16'h6FFF);
    send_frame(32'h6FFF, 16, 1'b0, 1'b1, "f6fff");
    check("f6fff_spd_pwr", {30'd0, spd, pwr}, 32'd3);

    // last sclk fall coincident with cs_n rise
    push_good(16'h4321);
    send_frame(32'h4321, 16, 1'b1, 1'b1, "simul");
    check("simul_dacb", {20'd0, dac_b}, 32'h321);

    // random good frames
    for (int k = 0; k < 4; k++) begin
      rv = 16'($urandom_range(0, 65535));
      push_good(rv);
      send_frame({16'd0, rv}, 16, 1'b0, 1'b1, "rand");
    end

    // timeout: 5 bits then sclk stalls with cs_n low
    @(negedge clk_50mhz);
    link.cs_n = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    for (int i = 0; i < 5; i++) begin
      link.din = i[0];
      link.sclk = 1'b1;
      repeat (2) @(negedge clk_50mhz);
      link.sclk = 1'b0;
      if (i < 4) repeat (2) @(negedge clk_50mhz);
    end
    t0 = cyc;
    push_err(2'b11);
    repeat (1100) @(negedge clk_50mhz);
    check("to_seen", exp_q.size(), 32'd0);
    check("to_when", {31'd0, (last_evt_cyc - t0 >= 1024) && (last_evt_cyc - t0 <= 1030)}, 32'd1);
    check("to_code", {30'd0, err_code}, 32'd3);
    link.cs_n = 1'b1;
    link.din  = 1'b1;
    repeat (3) @(posedge clk_50mhz);
    #1 check("to_cs_rise", {31'd0, rx_valid | rx_err}, 32'd0);
    repeat (6) @(negedge clk_50mhz);

    // reset at bit 8 aborts silently
    @(negedge clk_50mhz);
    link.cs_n = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    for (int i = 0; i < 8; i++) begin
      link.din = 1'b1;
      link.sclk = 1'b1;
      repeat (2) @(negedge clk_50mhz);
      link.sclk = 1'b0;
      repeat (2) @(negedge clk_50mhz);
    end
    rst_n = 1'b0;
    link.cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_50mhz);
    check("midrst_dac", {8'd0, dac_a, dac_b}, 32'd0);
    check("midrst_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    push_good(16'h9001);
    send_frame(32'h9001, 16, 1'b0, 1'b1, "f9001");
    check("f9001_dac", {8'd0, dac_a, dac_b}, 32'd0);
    check("f9001_spd_pwr", {30'd0, spd, pwr}, 32'd0);
    check("f9001_data", {16'd0, rx_data}, 32'h9001);

    // cs_n already low when reset releases -> short frame
    rst_n = 1'b0;
    link.cs_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50mhz);
    push_err(2'b01);
    link.cs_n = 1'b1;
    repeat (2) @(posedge clk_50mhz);
    #1 check("rstlow_early", {31'd0, rx_err}, 32'd0);
    @(posedge clk_50mhz);
    #1 check("rstlow_err", {31'd0, rx_err}, 32'd1);
    repeat (10) @(negedge clk_50mhz);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
